// File: rtl/mod_inverse.sv
// Sequential modular inverse (binary extended Euclid, one step per clock).
// Feeds k^-1 mod n / s^-1 mod n to the ECDSA signature stage.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset (aborts any operation)
//   start  - one-cycle request, sampled only while idle
//   a, m   - value to invert and odd modulus, latched on accepted start
//   busy   - high from the cycle after start through the done cycle
//   done   - one-cycle pulse, result valid
//   error  - valid with done; no inverse or illegal operands
//   inv    - result, held until the next accepted start (0 on error)

module mod_inverse #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] inv
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        LOOP,
        FINISH
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   XONE = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH:0]   x1_q, x1_d;
    logic [WIDTH:0]   x2_q, x2_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic [WIDTH:0]   m_ext;

    // x/2 mod m: an odd x is made even by adding m first; the extra
    // bit of x holds that sum since x < m < 2^WIDTH.
    function automatic logic [WIDTH:0] halve(
        input logic [WIDTH:0] x,
        input logic [WIDTH:0] md
    );
        logic [WIDTH:0] s;
        s = x[0] ? x + md : x;
        return s >> 1;
    endfunction

    // (p - q) mod m for p, q already in [0, m).
    function automatic logic [WIDTH:0] sub_mod(
        input logic [WIDTH:0] p,
        input logic [WIDTH:0] q,
        input logic [WIDTH:0] md
    );
        return (p >= q) ? p - q : p + md - q;
    endfunction

    assign m_ext = {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        m_d     = m_q;
        err_d   = err_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    u_d     = a;
                    v_d     = m;
                    x1_d    = XONE;
                    x2_d    = '0;
                    m_d     = m;
                    err_d   = 1'b0;
                    inv_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!m_q[0] || m_q <= ONE || u_q == '0 || u_q >= m_q) begin
                    err_d   = 1'b1;
                    inv_d   = '0;
                    state_d = FINISH;
                end else begin
                    state_d = LOOP;
                end
            end
            LOOP: begin
                // invariants: x1*a == u and x2*a == v (mod m)
                if (u_q == ONE) begin
                    inv_d   = x1_q[WIDTH-1:0];
                    state_d = FINISH;
                end else if (v_q == ONE) begin
                    inv_d   = x2_q[WIDTH-1:0];
                    state_d = FINISH;
                end else if (u_q == '0 || v_q == '0) begin
                    err_d   = 1'b1;
                    inv_d   = '0;
                    state_d = FINISH;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = halve(x1_q, m_ext);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = halve(x2_q, m_ext);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q, m_ext);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q, m_ext);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            m_q     <= '0;
            err_q   <= 1'b0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            m_q     <= m_d;
            err_q   <= err_d;
            inv_q   <= inv_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FINISH);
    assign error = err_q;
    assign inv   = inv_q;

endmodule

// File: doc/mod_inverse.md
Name: mod_inverse

Overview:
- Sequential modular inverse unit: computes inv = a^-1 mod m for odd m, using the binary extended Euclidean algorithm (one step per clock).
- Sits directly upstream of the ECDSA signature stage. It supplies k^-1 mod n for s = k^-1(z + r*d) mod n in signing.
- It also supplies s^-1 mod n (w) in verification.
- Operands are 256-bit secp256k1 scalars by default. Width is parameterised so small-width benches are possible.

Parameters:
- WIDTH, 256, operand/modulus width in bits.

Ports:
- clk    input   1      rising-edge clock.
- reset  input   1      synchronous, active-high reset.
- start  input   1      one-cycle request; sampled only in IDLE.
- a      input   WIDTH  value to invert; latched on accepted start.
- m      input   WIDTH  modulus (odd, > 1); latched on accepted start.
- busy   output  1      high from the cycle after an accepted start until the done cycle, inclusive.
- done   output  1      one-cycle pulse when the result is valid.
- error  output  1      valid with done; 1 = no inverse / illegal operands.
- inv    output  WIDTH  result; held until the next accepted start; 0 when error=1.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, error=0, inv=0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- Internal registers:
  - u, v: WIDTH bits.
  - x1, x2: WIDTH+1 bits, to hold x+m before halving.
  - latched m_r.
- IDLE:
  - start=1 latches a and m into u=a, v=m, x1=1, x2=0, m_r=m, then goes to CHECK.
  - Clears error and inv in the same cycle.
- CHECK (1 cycle):
  - If m even, m<=1, a==0, or a>=m, go to FINISH with error=1.
  - Otherwise go to LOOP.
- LOOP: exactly one action per cycle, in this priority order:
  1. u==1: go to FINISH with result x1.
  2. v==1: go to FINISH with result x2.
  3. u==0 or v==0: go to FINISH with error=1 (gcd != 1).
  4. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+m_r)>>1.
  5. v even: same update on v and x2.
  6. u>=v: u=u-v; x1 = (x1>=x2) ? x1-x2 : x1-x2+m_r.
  7. u<v: v=v-u; x2 = (x2>=x1) ? x2-x1 : x2-x1+m_r.
- Invariants: x1, x2 are always in [0, m_r). The addition before halving uses the extra bit and never overflows.
- FINISH (1 cycle):
  - done=1; busy drops in the following cycle; return to IDLE.
  - inv = selected x, or 0 when error=1.
  - error holds its value until the next accepted start.
- Latency:
  - Start-to-done is at most 4*WIDTH+4 cycles.
  - Minimum is 3 cycles (a=1: CHECK, LOOP sees u==1, FINISH).
- Simultaneous events: start asserted while busy, or in the FINISH cycle, is ignored and not queued. reset has priority over start.
- Inputs a and m may change freely after the start cycle; only the latched values are used.

Test Plan:
- WIDTH=8, m=251, a=3, start pulse: done within 36 cycles; inv=84, error=0. Repeat with a=2: inv=126. Sweep all a in 1..250 and check a*inv mod 251 == 1.
- WIDTH=8, m=9, a=3: done with error=1, inv=0. Also m=10 (even) and a=0: error=1, with done exactly 2 cycles after start.
- WIDTH=256, m=secp256k1 n (FFFF...FFFE BAAEDCE6 AF48A03B BFD25E8C D0364141):
  - a=1 gives inv=1, done 3 cycles after start.
  - a=n-1 gives inv=n-1.
  - Both complete within 1028 cycles.
- WIDTH=8, m=251, a=3 in flight; assert start with a=5 while busy: ignored, result inv=84. A following start with a=5 gives inv=201 (5*201=1005=4*251+1).
- WIDTH=8, m=251, a=7; assert reset for 1 cycle mid-LOOP:
  - busy/done/error/inv go to 0 the next cycle, with no done pulse.
  - A new start with a=7 gives inv=36 (7*36=252).
- Hold check: after done with inv=84, keep start low for 20 cycles. inv stays 84, done stays 0, busy stays 0.
